// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FP execute stage: field widths, flag
// positions, canonical NaN and the divider state encoding.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        ROUND,
        DONE
    } fdiv_state_t;

    function automatic logic [31:0] fpInf(input logic sign);
        return {sign, 8'hFF, 23'h000000};
    endfunction

    function automatic logic [31:0] fpZero(input logic sign);
        return {sign, 31'h00000000};
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 unpacker; subnormals (exponent 0) are reported as zero.
module fp32_classify
    import fp_pkg::*;
(
    input  logic [31:0]          data_i,
    output logic                 sign_o,
    output logic [FP_EXP_W-1:0]  exp_o,
    output logic [FP_MANT_W-1:0] mant_o,
    output logic                 is_zero_o,
    output logic                 is_inf_o,
    output logic                 is_nan_o,
    output logic                 is_snan_o
);

    logic expAllOnes;
    logic mantNonZero;

    assign sign_o      = data_i[31];
    assign exp_o       = data_i[30:23];
    assign mant_o      = data_i[22:0];

    assign expAllOnes  = (data_i[30:23] == 8'hFF);
    assign mantNonZero = (data_i[22:0] != 23'h0);

    assign is_zero_o   = (data_i[30:23] == 8'h00);
    assign is_inf_o    = expAllOnes && !mantNonZero;
    assign is_nan_o    = expAllOnes && mantNonZero;
    // A NaN with the quiet bit clear is signalling.
    assign is_snan_o   = expAllOnes && mantNonZero && !data_i[22];

endmodule

// File: rtl/fp_div_unit.sv
// Iterative FDIV.S: radix-2 restoring divider with round-to-nearest-even,
// special-case bypass and one-cycle writeback strobe.
module fp_div_unit
    import fp_pkg::*;
#(
    parameter int ITER = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [31:0] i_frs1_data,
    input  logic [31:0] i_frs2_data,
    input  logic [4:0]  i_frd_index,
    output logic        o_busy,
    output logic        o_wb_en_f,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_frd_index,
    output logic [4:0]  o_fflags
);

    localparam int CNT_W = $clog2(ITER);

    fdiv_state_t state_q, state_d;

    logic [31:0]      opA_q, opA_d;
    logic [31:0]      opB_q, opB_d;
    logic [4:0]       idx_q, idx_d;
    logic             sign_q, sign_d;
    logic [9:0]       exp_q, exp_d;
    logic [23:0]      divisor_q, divisor_d;
    logic [25:0]      rem_q, rem_d;
    logic [ITER-1:0]  quot_q, quot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wbData_q, wbData_d;
    logic [4:0]       wbIdx_q, wbIdx_d;
    logic [4:0]       flags_q, flags_d;

    logic                 aSign, bSign;
    logic [FP_EXP_W-1:0]  aExp, bExp;
    logic [FP_MANT_W-1:0] aMant, bMant;
    logic                 aZero, bZero, aInf, bInf, aNan, bNan, aSnan, bSnan;

    fp32_classify uClassA (
        .data_i    (opA_q),
        .sign_o    (aSign),
        .exp_o     (aExp),
        .mant_o    (aMant),
        .is_zero_o (aZero),
        .is_inf_o  (aInf),
        .is_nan_o  (aNan),
        .is_snan_o (aSnan)
    );

    fp32_classify uClassB (
        .data_i    (opB_q),
        .sign_o    (bSign),
        .exp_o     (bExp),
        .mant_o    (bMant),
        .is_zero_o (bZero),
        .is_inf_o  (bInf),
        .is_nan_o  (bNan),
        .is_snan_o (bSnan)
    );

    logic        resSign;
    logic [23:0] mantAFull, mantBFull;
    logic        needShift;
    logic [9:0]  expCalc;

    assign resSign   = aSign ^ bSign;
    assign mantAFull = {1'b1, aMant};
    assign mantBFull = {1'b1, bMant};
    // Pre-normalising the dividend keeps the first quotient bit at 1.
    assign needShift = (mantAFull < mantBFull);
    assign expCalc   = {2'b00, aExp} - {2'b00, bExp} + 10'(FP_BIAS) - {9'b0, needShift};

    logic        isSpecial;
    logic [31:0] specData;
    logic [4:0]  specFlags;

    always_comb begin
        isSpecial = 1'b1;
        specData  = FP_CANON_NAN;
        specFlags = '0;
        if (aNan || bNan) begin
            specFlags[FLAG_NV] = aSnan | bSnan;
        end else if ((aZero && bZero) || (aInf && bInf)) begin
            specFlags[FLAG_NV] = 1'b1;
        end else if (aInf) begin
            specData = fpInf(resSign);
        end else if (bZero) begin
            specData           = fpInf(resSign);
            specFlags[FLAG_DZ] = 1'b1;
        end else if (bInf || aZero) begin
            specData = fpZero(resSign);
        end else begin
            isSpecial = 1'b0;
        end
    end

    logic        guardBit, stickyBit, roundUp, inexact;
    logic [24:0] mantRnd;
    logic [22:0] fracRnd;
    logic [9:0]  expRnd;
    logic [31:0] roundData;
    logic [4:0]  roundFlags;

    always_comb begin
        guardBit   = quot_q[0];
        stickyBit  = (rem_q != 26'd0);
        roundUp    = guardBit & (stickyBit | quot_q[1]);
        inexact    = guardBit | stickyBit;
        mantRnd    = {1'b0, quot_q[ITER-1:1]} + {24'b0, roundUp};
        fracRnd    = mantRnd[24] ? mantRnd[23:1] : mantRnd[22:0];
        expRnd     = exp_q + {9'b0, mantRnd[24]};
        roundData  = {sign_q, expRnd[7:0], fracRnd};
        roundFlags = '0;
        roundFlags[FLAG_NX] = inexact;
        if ($signed(expRnd) >= 10'sd255) begin
            roundData           = fpInf(sign_q);
            roundFlags[FLAG_OF] = 1'b1;
            roundFlags[FLAG_NX] = 1'b1;
        end else if ($signed(expRnd) <= 10'sd0) begin
            roundData           = fpZero(sign_q);
            roundFlags[FLAG_UF] = 1'b1;
            roundFlags[FLAG_NX] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        idx_d     = idx_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        wbData_d  = wbData_q;
        wbIdx_d   = wbIdx_q;
        flags_d   = flags_q;

        case (state_q)
            IDLE: begin
                if (i_start && !i_flush) begin
                    opA_d   = i_frs1_data;
                    opB_d   = i_frs2_data;
                    idx_d   = i_frd_index;
                    state_d = PREP;
                end
            end
            PREP: begin
                sign_d    = resSign;
                exp_d     = expCalc;
                divisor_d = mantBFull;
                rem_d     = needShift ? {1'b0, mantAFull, 1'b0} : {2'b00, mantAFull};
                quot_d    = '0;
                cnt_d     = '0;
                if (isSpecial) begin
                    wbData_d = specData;
                    flags_d  = specFlags;
                    wbIdx_d  = idx_q;
                    state_d  = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rem_q >= {2'b00, divisor_q}) begin
                    rem_d  = (rem_q - {2'b00, divisor_q}) << 1;
                    quot_d = {quot_q[ITER-2:0], 1'b1};
                end else begin
                    rem_d  = rem_q << 1;
                    quot_d = {quot_q[ITER-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                wbData_d = roundData;
                flags_d  = roundFlags;
                wbIdx_d  = idx_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A squash abandons the operation and leaves the last result visible.
        if (i_flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            wbData_d = wbData_q;
            wbIdx_d  = wbIdx_q;
            flags_d  = flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            idx_q     <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            wbData_q  <= '0;
            wbIdx_q   <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            idx_q     <= idx_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            cnt_q     <= cnt_d;
            wbData_q  <= wbData_d;
            wbIdx_q   <= wbIdx_d;
            flags_q   <= flags_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_wb_en_f   = (state_q == DONE);
    assign o_wb_data   = wbData_q;
    assign o_frd_index = wbIdx_q;
    assign o_fflags    = flags_q;

endmodule

// File: tb/tb_fp_div_unit.sv
// Scoreboard bench for fp_div_unit: directed vectors push expected results,
// a negedge monitor pops and checks data, flags, index and strobe cycle.
module tb_fp_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_flush;
    logic [31:0] i_frs1_data;
    logic [31:0] i_frs2_data;
    logic [4:0]  i_frd_index;
    logic        o_busy;
    logic        o_wb_en_f;
    logic [31:0] o_wb_data;
    logic [4:0]  o_frd_index;
    logic [4:0]  o_fflags;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        logic [4:0]  idx;
        int          cycle;
    } expect_t;

    expect_t expQ[$];
    expect_t popped;

    int totalCount  = 0;
    int badCount    = 0;
    int cycleCnt    = 0;
    int strobeCount = 0;
    int issueCount  = 0;

    fp_div_unit #(.ITER(25)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_flush     (i_flush),
        .i_frs1_data (i_frs1_data),
        .i_frs2_data (i_frs2_data),
        .i_frd_index (i_frd_index),
        .o_busy      (o_busy),
        .o_wb_en_f   (o_wb_en_f),
        .o_wb_data   (o_wb_data),
        .o_frd_index (o_frd_index),
        .o_fflags    (o_fflags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && o_wb_en_f === 1'b1) begin
            strobeCount++;
            if (expQ.size() == 0) begin
                totalCount++;
                badCount++;
                $display("[TB] FAIL unexpectedStrobe: got data 0x%08h, want no strobe (cycle %0d)", o_wb_data, cycleCnt);
            end else begin
                popped = expQ.pop_front();
                checkOutput("wbData", o_wb_data, popped.data);
                checkOutput("fflags", {27'b0, o_fflags}, {27'b0, popped.flags});
                checkOutput("frdIndex", {27'b0, o_frd_index}, {27'b0, popped.idx});
                checkOutput("strobeCycle", cycleCnt, popped.cycle);
            end
        end
    end

    // Issues one start in the current cycle; leaves the bench one cycle later.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] idx,
                                 input bit expectIt, input logic [31:0] expData,
                                 input logic [4:0] expFlags, input int latency);
        expect_t e;
        i_frs1_data = a;
        i_frs2_data = b;
        i_frd_index = idx;
        i_start     = 1'b1;
        if (expectIt) begin
            e.data  = expData;
            e.flags = expFlags;
            e.idx   = idx;
            e.cycle = cycleCnt + latency;
            expQ.push_back(e);
            issueCount++;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (o_busy !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idleTimeout", {31'b0, o_busy}, 32'd0);
    endtask

    task automatic runVec(input logic [31:0] a, input logic [31:0] b, input logic [4:0] idx,
                          input logic [31:0] expData, input logic [4:0] expFlags, input int latency);
        applyStimulus(a, b, idx, 1'b1, expData, expFlags, latency);
        checkOutput("busyAfterAccept", {31'b0, o_busy}, 32'd1);
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_flush     = 1'b0;
        i_frs1_data = '0;
        i_frs2_data = '0;
        i_frd_index = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", {31'b0, o_busy}, 32'd0);
        checkOutput("rstWbEn", {31'b0, o_wb_en_f}, 32'd0);
        checkOutput("rstData", o_wb_data, 32'd0);
        checkOutput("rstIndex", {27'b0, o_frd_index}, 32'd0);
        checkOutput("rstFlags", {27'b0, o_fflags}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runVec(32'h40C00000, 32'h40000000, 5'd5,  32'h40400000, 5'h00, 28);
        runVec(32'h3F800000, 32'h40400000, 5'd7,  32'h3EAAAAAB, 5'h01, 28);
        runVec(32'h40000000, 32'h40400000, 5'd8,  32'h3F2AAAAB, 5'h01, 28);
        runVec(32'hC0C00000, 32'h40000000, 5'd31, 32'hC0400000, 5'h00, 28);
        runVec(32'h3F800000, 32'h00000000, 5'd3,  32'h7F800000, 5'h08, 2);
        runVec(32'h80000000, 32'h00000000, 5'd4,  32'h7FC00000, 5'h10, 2);
        runVec(32'h7F7FFFFF, 32'h3E800000, 5'd10, 32'h7F800000, 5'h05, 28);
        runVec(32'h00800000, 32'h40000000, 5'd11, 32'h00000000, 5'h03, 28);
        runVec(32'h7F800001, 32'h3F800000, 5'd12, 32'h7FC00000, 5'h10, 2);
        runVec(32'h7FC00000, 32'h3F800000, 5'd13, 32'h7FC00000, 5'h00, 2);
        runVec(32'h7F800000, 32'h7F800000, 5'd14, 32'h7FC00000, 5'h10, 2);
        runVec(32'h7F800000, 32'h40000000, 5'd15, 32'h7F800000, 5'h00, 2);
        runVec(32'hC0000000, 32'h7F800000, 5'd16, 32'h80000000, 5'h00, 2);
        runVec(32'h00000000, 32'h40A00000, 5'd17, 32'h00000000, 5'h00, 2);
        runVec(32'h3F800000, 32'h3F800000, 5'd1,  32'h3F800000, 5'h00, 28);

        // Flush in T+10: idle in T+11, restart there, result at T+39.
        applyStimulus(32'h40C00000, 32'h40000000, 5'd20, 1'b0, 32'h0, 5'h0, 0);
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        checkOutput("flushBusy", {31'b0, o_busy}, 32'd0);
        checkOutput("flushKeepsData", o_wb_data, 32'h3F800000);
        checkOutput("flushKeepsIndex", {27'b0, o_frd_index}, 32'd1);
        runVec(32'h40C00000, 32'h40000000, 5'd21, 32'h40400000, 5'h00, 28);

        // Start held high while busy must not queue a second operation.
        applyStimulus(32'h40C00000, 32'h40000000, 5'd9, 1'b1, 32'h40400000, 5'h00, 28);
        i_frs1_data = 32'h3F800000;
        i_frs2_data = 32'h00000000;
        i_frd_index = 5'd2;
        for (int k = 0; k < 28; k++) begin
            i_start = 1'b1;
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("noQueuedStart", {31'b0, o_busy}, 32'd0);

        // Synchronous reset mid-DIV clears every output on the next cycle.
        applyStimulus(32'h3F800000, 32'h40400000, 5'd6, 1'b0, 32'h0, 5'h0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstBusy", {31'b0, o_busy}, 32'd0);
        checkOutput("midRstWbEn", {31'b0, o_wb_en_f}, 32'd0);
        checkOutput("midRstData", o_wb_data, 32'd0);
        checkOutput("midRstIndex", {27'b0, o_frd_index}, 32'd0);
        checkOutput("midRstFlags", {27'b0, o_fflags}, 32'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        checkOutput("pendingResults", expQ.size(), 32'd0);
        checkOutput("strobeCount", strobeCount, issueCount);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
